// File: rtl/cont_pkg.sv
// Shared definitions for the irrigation counters (ascending cont_zero_cinco
// and its descending 5->0 counterpart).
//   state_t      : 2-bit state encoding of the counter FSM
//   CNT_W        : width of the count register
//   MAX_DEF      : default terminal count shared by both counters
//   next_up      : saturating +1 helper on a count value
package cont_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    FIN   = 2'b10
  } state_t;

  localparam int CNT_W   = 3;
  localparam int MAX_DEF = 5;

  // Increment that never rolls past 7; the FSM already stops at MAX, so the
  // saturation only guards against an illegal count value after an upset.
  function automatic logic [CNT_W-1:0] next_up(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cont_zero_cinco_if.sv
// Control/status bundle between the irrigation control FSM, the time base
// and the ascending counter.
//   Start, Stop : level commands from the control FSM
//   Enable      : time-base tick
//   Q2..Q0      : registered count, MSB to LSB
//   Busy, Done  : counting flag and one-cycle completion pulse
// master = controller side, slave = counter side.
interface cont_zero_cinco_if;
  logic Start;
  logic Stop;
  logic Enable;
  logic Q2;
  logic Q1;
  logic Q0;
  logic Busy;
  logic Done;

  modport master (
    output Start,
    output Stop,
    output Enable,
    input  Q2,
    input  Q1,
    input  Q0,
    input  Busy,
    input  Done
  );

  modport slave (
    input  Start,
    input  Stop,
    input  Enable,
    output Q2,
    output Q1,
    output Q0,
    output Busy,
    output Done
  );
endinterface

// File: rtl/ff_d_sinc.sv
// Single D flip-flop with synchronous active-high reset to 0.
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   d   : next value
//   q   : registered value
module ff_d_sinc (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/cont_zero_cinco.sv
// Ascending 0->MAX counter measuring the valve-open window. Start (re)starts
// from 0, Stop aborts to idle, each Enable tick advances the count; reaching
// MAX yields a one-cycle Done pulse (FIN state), after which the counter
// either idles holding MAX (WRAP=0) or restarts from 0 (WRAP=1).
//   Clk : system clock, all state changes on the rising edge
//   Rst : synchronous active-high reset (state IDLE, Q=0)
//   bus : slave side of cont_zero_cinco_if (Start/Stop/Enable in,
//         Q2..Q0/Busy/Done out)
// Parameters: MAX terminal count (1..7), WRAP auto-restart select.
module cont_zero_cinco
  import cont_pkg::*;
#(
  parameter int MAX  = MAX_DEF,
  parameter int WRAP = 0
) (
  input  logic               Clk,
  input  logic               Rst,
  cont_zero_cinco_if.slave   bus
);

  localparam logic [CNT_W-1:0] MAX_Q  = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] LAST_Q = CNT_W'(MAX - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       st_bits;
  logic [1:0]       st_next_bits;
  state_t           st;
  state_t           st_next;

  // Register bank: every state and count bit is its own sync-reset flop;
  // reset priority over every input therefore lives in the flops.
  for (genvar i = 0; i < CNT_W; i++) begin : g_cnt
    ff_d_sinc u_ff (
      .clk (Clk),
      .rst (Rst),
      .d   (cnt_next[i]),
      .q   (cnt[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_st
    ff_d_sinc u_ff (
      .clk (Clk),
      .rst (Rst),
      .d   (st_next_bits[i]),
      .q   (st_bits[i])
    );
  end

  assign st           = state_t'(st_bits);
  assign st_next_bits = st_next;

  // Next-state / next-count: Stop > Start > state-specific behaviour.
  always_comb begin
    st_next  = st;
    cnt_next = cnt;
    if (bus.Stop) begin
      st_next  = IDLE;
      cnt_next = '0;
    end else if (bus.Start) begin
      st_next  = COUNT;
      cnt_next = '0;
    end else begin
      case (st)
        IDLE: begin
          // Enable ignored; count holds 0 or the MAX of a finished run.
          st_next  = IDLE;
          cnt_next = cnt;
        end
        COUNT: begin
          if (bus.Enable) begin
            if (cnt == LAST_Q) begin
              st_next  = FIN;
              cnt_next = MAX_Q;
            end else begin
              cnt_next = next_up(cnt);
            end
          end
        end
        FIN: begin
          // FIN lasts exactly one cycle regardless of Enable.
          if (WRAP != 0) begin
            st_next  = COUNT;
            cnt_next = '0;
          end else begin
            st_next  = IDLE;
            cnt_next = cnt;
          end
        end
        default: begin
          // Unused encoding 2'b11: recover to a clean idle.
          st_next  = IDLE;
          cnt_next = '0;
        end
      endcase
    end
  end

  // Outputs decoded from registers only; no input reaches them combinationally.
  assign bus.Q2   = cnt[2];
  assign bus.Q1   = cnt[1];
  assign bus.Q0   = cnt[0];
  assign bus.Busy = (st == COUNT);
  assign bus.Done = (st == FIN);

endmodule

// File: tb/tb_cont_zero_cinco.sv
// Scoreboard bench: three counters (MAX5/WRAP0, MAX5/WRAP1, MAX1/WRAP0) share
// one stimulus stream; a behavioural model pushes the expected outputs per
// edge and a monitor pops and compares just after each rising edge.
module tb_cont_zero_cinco;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cont_zero_cinco_if bus5 ();
  cont_zero_cinco_if busw ();
  cont_zero_cinco_if bus1 ();

  cont_zero_cinco #(.MAX(5), .WRAP(0)) u_c5 (.Clk(clk), .Rst(rst), .bus(bus5));
  cont_zero_cinco #(.MAX(5), .WRAP(1)) u_cw (.Clk(clk), .Rst(rst), .bus(busw));
  cont_zero_cinco #(.MAX(1), .WRAP(0)) u_c1 (.Clk(clk), .Rst(rst), .bus(bus1));

  typedef struct {
    int q;
    bit busy;
    bit done;
  } mdl_t;

  mdl_t m5, mw, m1;
  mdl_t q5[$];
  mdl_t qw[$];
  mdl_t q1[$];

  int n_vec = 0;
  int n_err = 0;

  // Behaviour from the rules: a run is either idle, counting, or just done.
  function automatic mdl_t step(mdl_t s, int max, bit wrap,
                                bit r, bit st, bit sp, bit en);
    mdl_t o;
    o = s;
    if (r || sp) begin
      o.q = 0; o.busy = 0; o.done = 0;
    end else if (st) begin
      o.q = 0; o.busy = 1; o.done = 0;
    end else if (s.done) begin
      o.done = 0;
      if (wrap) begin
        o.q = 0; o.busy = 1;
      end else begin
        o.busy = 0;
      end
    end else if (s.busy && en) begin
      o.q = s.q + 1;
      if (o.q == max) begin
        o.busy = 0; o.done = 1;
      end
    end
    return o;
  endfunction

  task automatic tick(bit r, bit st, bit sp, bit en);
    rst = r;
    bus5.Start = st; bus5.Stop = sp; bus5.Enable = en;
    busw.Start = st; busw.Stop = sp; busw.Enable = en;
    bus1.Start = st; bus1.Stop = sp; bus1.Enable = en;
    m5 = step(m5, 5, 1'b0, r, st, sp, en); q5.push_back(m5);
    mw = step(mw, 5, 1'b1, r, st, sp, en); qw.push_back(mw);
    m1 = step(m1, 1, 1'b0, r, st, sp, en); q1.push_back(m1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(string nm, mdl_t e, logic q2, logic q1b, logic q0,
                       logic busy, logic done);
    logic [2:0] a;
    logic [2:0] w;
    a = {q2, q1b, q0};
    w = 3'(e.q);
    n_vec++;
    if (a !== w || busy !== e.busy || done !== e.done) begin
      n_err++;
      $display("FAIL %s t=%0t: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
               nm, $time, a, busy, done, w, e.busy, e.done);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q5.size() > 0) check("max5_wrap0", q5.pop_front(), bus5.Q2, bus5.Q1, bus5.Q0, bus5.Busy, bus5.Done);
      if (qw.size() > 0) check("max5_wrap1", qw.pop_front(), busw.Q2, busw.Q1, busw.Q0, busw.Busy, busw.Done);
      if (q1.size() > 0) check("max1_wrap0", q1.pop_front(), bus1.Q2, bus1.Q1, bus1.Q0, bus1.Busy, bus1.Done);
    end
  end

  initial begin
    m5 = '{0, 1'b0, 1'b0};
    mw = '{0, 1'b0, 1'b0};
    m1 = '{0, 1'b0, 1'b0};
    bus5.Start = 0; bus5.Stop = 0; bus5.Enable = 0;
    busw.Start = 0; busw.Stop = 0; busw.Enable = 0;
    bus1.Start = 0; bus1.Stop = 0; bus1.Enable = 0;
    @(negedge clk);

    // Reset, then Enable in idle has no effect
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 1);
    // Reset mid-count at Q=3, Enable afterwards ignored
    tick(0, 1, 0, 0);
    repeat (3) tick(0, 0, 0, 1);
    tick(1, 0, 0, 1);
    repeat (2) tick(0, 0, 0, 1);
    // Full count with Enable held
    tick(0, 1, 0, 0);
    repeat (8) tick(0, 0, 0, 1);
    // Enable every other cycle
    tick(0, 1, 0, 0);
    for (int i = 0; i < 14; i++) tick(0, 0, 0, i[0]);
    // Stop at Q=2
    tick(0, 1, 0, 0);
    repeat (2) tick(0, 0, 0, 1);
    tick(0, 0, 1, 1);
    tick(0, 0, 0, 1);
    // Start and Stop together: Stop wins
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 1, 1, 1);
    tick(0, 0, 0, 1);
    // Restart at Q=4
    tick(0, 1, 0, 0);
    repeat (4) tick(0, 0, 0, 1);
    tick(0, 1, 0, 1);
    repeat (3) tick(0, 0, 0, 1);
    // Long run for wrap behaviour
    tick(0, 1, 0, 0);
    repeat (14) tick(0, 0, 0, 1);
    // MAX=1: Start during FIN, then Stop during FIN
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 1);
    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 199) < 1, $urandom_range(0, 99) < 6,
           $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 65);
    end

    @(posedge clk);
    #2;
    n_vec++;
    if (q5.size() + qw.size() + q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", q5.size() + qw.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cont_zero_cinco.md
# cont_zero_cinco

Synchronous ascending counter 0→MAX (default 5) with start/stop control, busy flag and one-cycle completion pulse. It is the counterpart of the irrigation system's descending 5→0 counter. The descending counter measures the wait interval down to zero; this block measures the valve-open window upward from zero. It sits between the irrigation control FSM (Start/Stop) and the system time base (Enable tick).

## Interface
Parameters:
- MAX, 5: terminal count; legal range 1..7.
- WRAP, 0: 0 = stop at MAX after completion; 1 = restart from 0 automatically.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Rst  in  1  reset; synchronous, active-high.
- Start  in  1  level, sampled each edge; (re)starts the count from 0.
- Stop  in  1  level, sampled each edge; aborts the count, returns to idle.
- Enable  in  1  time-base tick; one increment per edge where it is high.
- Q2, Q1, Q0  out  1 each  registered count, MSB to LSB.
- Busy  out  1  high while counting.
- Done  out  1  one-cycle pulse when the count reaches MAX.

## Operation
- States: IDLE, COUNT, FIN.
- Priority at every edge: Rst > Stop > Start > Enable.
- Rst: state←IDLE, Q←0, Busy=0, Done=0. Applies mid-count as well; it overrides all other inputs.
- IDLE:
  - Busy=0, Done=0.
  - Enable is ignored.
  - Q holds its value: 0 after reset/Stop, or MAX after a WRAP=0 completion.
  - Start: Q←0, →COUNT.
- COUNT:
  - Busy=1.
  - Enable with Q<MAX−1: Q←Q+1.
  - Enable with Q=MAX−1: Q←MAX, →FIN.
  - Start: Q←0, stay in COUNT (restart, no Done).
  - Stop: Q←0, →IDLE, no Done.
- FIN:
  - Done=1, Busy=0, Q=MAX; the state lasts exactly one cycle.
  - Next state, WRAP=0: →IDLE with Q held at MAX.
  - Next state, WRAP=1: Q←0, →COUNT.
  - Start in FIN: Q←0, →COUNT. Done still pulses in this cycle.
  - Stop in FIN: Q←0, →IDLE. Done still pulses in this cycle.
  - Enable in FIN is ignored.
- Start and Stop in the same cycle: Stop wins.
- MAX=1: the first Enable in COUNT goes straight to FIN.
- Arithmetic: 3-bit unsigned. Q never exceeds MAX, so no overflow or wrap past 7 exists.
- Busy and Done are decoded from the state register only, so they are glitch-free and registered-equivalent.

## Timing
- All outputs change only after a rising edge of Clk; there are no combinational input→output paths.
- Start sampled at edge n: Busy=1 and Q=0 from edge n.
- With Enable held high from edge n+1:
  - Q=k after edge n+k.
  - Q=MAX and Done=1 after edge n+MAX.
  - Done falls after edge n+MAX+1.
- Latency Start→Done = MAX Enable ticks, plus the FIN cycle.
- Enable gaps stretch the count. Q holds through cycles with Enable low.
- Reset value of every output: Q2=Q1=Q0=0, Busy=0, Done=0.

## Structure
- Shared package cont_pkg:
  - state encoding IDLE=2'b00, COUNT=2'b01, FIN=2'b10;
  - count width constant 3;
  - default terminal count 5, also used by the descending counter.
- One sub-module: ff_d_sinc, a D flip-flop with synchronous active-high reset.
  - Instantiated for the 3 count bits and the 2 state bits.
  - Next-value logic stays in cont_zero_cinco.

## Test plan
- Reset during COUNT with Q=3: Rst high for 1 cycle → Q=0, Busy=0, Done=0 after that edge; Enable afterwards has no effect.
- Start, then Enable held high, MAX=5, WRAP=0:
  - Q steps 0,1,2,3,4,5 on consecutive edges.
  - Done=1 for exactly one cycle while Q=5.
  - Then IDLE with Q=5 held and Busy=0.
- Enable toggled every other cycle: Q advances only on ticks; Done is reached after 5 ticks, i.e. about 10 cycles.
- Start and Stop during counting:
  - Stop at Q=2 → Q=0, IDLE, no Done pulse.
  - Start and Stop in the same cycle → Stop wins.
  - Start at Q=4 → Q=0, stays Busy.
- WRAP=1, Enable held high: Done pulses every 6 cycles (5 ticks + FIN); Q sequence 0..5,0..5.
- MAX=1: Start, then one Enable → Q=1, Done pulse on the next cycle; Start during FIN → COUNT with Q=0 and the Done pulse still observed.
